// File: rtl/brick_pkg.sv
// Shared types and sizing for the breakout brick wall: coordinate types,
// index widths and the collision-scan state encoding.
package brick_pkg;

    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 8;
    localparam int NBRICKS  = DEF_ROWS * DEF_COLS;
    localparam int MAX_ROWS = 8;
    localparam int MAX_COLS = 16;

    localparam int ROW_W = $clog2(MAX_ROWS);
    localparam int COL_W = $clog2(MAX_COLS);
    localparam int IDX_W = $clog2(MAX_ROWS * MAX_COLS);

    // Screen coordinate as used by board, ball and pixel_generation.
    typedef logic [9:0]  coord_t;
    // One extra bit so sums and differences of coordinates never wrap.
    typedef logic [10:0] wcoord_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/brick_overlap.sv
// Axis-aligned box overlap between the ball square and one brick rectangle,
// evaluated in 11-bit arithmetic so the right/bottom edges never wrap.
module brick_overlap
    import brick_pkg::*;
#(
    parameter int BRICK_W   = 56,
    parameter int BRICK_H   = 12,
    parameter int BALL_SIZE = 8
) (
    input  logic    [9:0]  ball_x,
    input  logic    [9:0]  ball_y,
    input  logic    [10:0] brick_x,
    input  logic    [10:0] brick_y,
    output logic           overlap
);

    wcoord_t bx_lo, by_lo, bx_hi, by_hi, kx_hi, ky_hi;

    always_comb begin
        bx_lo   = {1'b0, ball_x};
        by_lo   = {1'b0, ball_y};
        bx_hi   = bx_lo + wcoord_t'(BALL_SIZE);
        by_hi   = by_lo + wcoord_t'(BALL_SIZE);
        kx_hi   = brick_x + wcoord_t'(BRICK_W);
        ky_hi   = brick_y + wcoord_t'(BRICK_H);
        overlap = (bx_lo < kx_hi) && (brick_x < bx_hi) &&
                  (by_lo < ky_hi) && (brick_y < by_hi);
    end

endmodule

// File: rtl/brick_wall.sv
// ROWS x COLS brick field: per-pixel live-brick lookup plus a one-brick-per-clock
// collision scan that destroys the lowest-index overlapping brick per ball update.
module brick_wall
    import brick_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int ORIGIN_X  = 8,
    parameter int ORIGIN_Y  = 60,
    parameter int COL_SHIFT = 6,
    parameter int ROW_SHIFT = 4,
    parameter int BRICK_W   = 56,
    parameter int BRICK_H   = 12,
    parameter int BALL_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       ball_valid,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       brick_on,
    output logic       busy,
    output logic       hit,
    output logic [2:0] hit_row,
    output logic [3:0] hit_col,
    output logic [7:0] bricks_left,
    output logic       cleared
);

    localparam int NB = ROWS * COLS;

    logic [NB-1:0] alive;
    state_t        state;
    coord_t        lat_x, lat_y;
    logic [ROW_W-1:0] scan_row, pend_row;
    logic [COL_W-1:0] scan_col, pend_col;
    logic          pend_hit;

    // Pixel path: locate the brick cell under the pixel, then test the gap and liveness.
    wcoord_t dx, dy, pcol, prow;
    logic [IDX_W-1:0] pidx;
    logic [NB-1:0] pshift;
    logic          pix_hit;

    always_comb begin
        dx      = {1'b0, pix_x} - wcoord_t'(ORIGIN_X);
        dy      = {1'b0, pix_y} - wcoord_t'(ORIGIN_Y);
        pcol    = dx >> COL_SHIFT;
        prow    = dy >> ROW_SHIFT;
        pidx    = IDX_W'(prow * wcoord_t'(COLS) + pcol);
        pshift  = alive >> pidx;
        pix_hit = !dx[10] && !dy[10] &&
                  (pcol < wcoord_t'(COLS)) && (prow < wcoord_t'(ROWS)) &&
                  (wcoord_t'(dx[COL_SHIFT-1:0]) < wcoord_t'(BRICK_W)) &&
                  (wcoord_t'(dy[ROW_SHIFT-1:0]) < wcoord_t'(BRICK_H)) &&
                  pshift[0];
    end

    always_ff @(posedge clk) begin
        if (rst) brick_on <= 1'b0;
        else     brick_on <= pix_hit;
    end

    // Scan path: box of the brick currently addressed by the scan counters.
    wcoord_t brick_x, brick_y;
    logic [IDX_W-1:0] scan_idx;
    logic [NB-1:0] sshift;
    logic          scan_overlap, scan_last;

    always_comb begin
        brick_x   = wcoord_t'(ORIGIN_X) + (wcoord_t'(scan_col) << COL_SHIFT);
        brick_y   = wcoord_t'(ORIGIN_Y) + (wcoord_t'(scan_row) << ROW_SHIFT);
        scan_idx  = IDX_W'(scan_row) * IDX_W'(COLS) + IDX_W'(scan_col);
        sshift    = alive >> scan_idx;
        scan_last = (scan_row == ROW_W'(ROWS - 1)) && (scan_col == COL_W'(COLS - 1));
    end

    brick_overlap #(
        .BRICK_W  (BRICK_W),
        .BRICK_H  (BRICK_H),
        .BALL_SIZE(BALL_SIZE)
    ) u_overlap (
        .ball_x (lat_x),
        .ball_y (lat_y),
        .brick_x(brick_x),
        .brick_y(brick_y),
        .overlap(scan_overlap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            alive       <= '1;
            bricks_left <= 8'(NB);
            state       <= ST_IDLE;
            busy        <= 1'b0;
            hit         <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            cleared     <= 1'b0;
            lat_x       <= '0;
            lat_y       <= '0;
            scan_row    <= '0;
            scan_col    <= '0;
            pend_row    <= '0;
            pend_col    <= '0;
            pend_hit    <= 1'b0;
        end else if (load) begin
            alive       <= '1;
            bricks_left <= 8'(NB);
            cleared     <= 1'b0;
            state       <= ST_IDLE;
            busy        <= 1'b0;
            hit         <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ball_valid) begin
                        lat_x    <= ball_x;
                        lat_y    <= ball_y;
                        scan_row <= '0;
                        scan_col <= '0;
                        pend_hit <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (sshift[0] && scan_overlap) begin
                        alive    <= alive & ~(NB'(1) << scan_idx);
                        pend_hit <= 1'b1;
                        pend_row <= scan_row;
                        pend_col <= scan_col;
                        state    <= ST_REPORT;
                    end else if (scan_last) begin
                        state <= ST_REPORT;
                    end else if (scan_col == COL_W'(COLS - 1)) begin
                        scan_col <= '0;
                        scan_row <= scan_row + 1'b1;
                    end else begin
                        scan_col <= scan_col + 1'b1;
                    end
                end
                ST_REPORT: begin
                    // The count guard keeps bricks_left from wrapping below zero.
                    if (pend_hit && bricks_left != 8'd0) begin
                        hit         <= 1'b1;
                        hit_row     <= pend_row;
                        hit_col     <= pend_col;
                        bricks_left <= bricks_left - 8'd1;
                        if (bricks_left == 8'd1) cleared <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brick_wall.sv
// Self-checking bench for brick_wall: pixel vector table, model-checked random
// ball strobes, and hand sequences for load, rst, back-to-back strobes and clearing.
module tb_brick_wall;

    localparam int ROWS = 3;
    localparam int COLS = 8;
    localparam int NB   = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       ball_valid = 1'b0;
    logic [9:0] ball_x = '0, ball_y = '0, pix_x = '0, pix_y = '0;
    logic       brick_on, busy, hit, cleared;
    logic [2:0] hit_row;
    logic [3:0] hit_col;
    logic [7:0] bricks_left;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_alive [ROWS][COLS];
    int m_left;
    bit m_cleared;

    brick_wall dut (
        .clk(clk), .rst(rst), .load(load), .ball_valid(ball_valid),
        .ball_x(ball_x), .ball_y(ball_y), .pix_x(pix_x), .pix_y(pix_y),
        .brick_on(brick_on), .busy(busy), .hit(hit), .hit_row(hit_row),
        .hit_col(hit_col), .bricks_left(bricks_left), .cleared(cleared)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: bricks as rectangles on screen, searched in row-major order.
    task automatic model_fill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) m_alive[r][c] = 1'b1;
        m_left    = NB;
        m_cleared = 1'b0;
    endtask

    function automatic bit model_pixel(input int x, input int y);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int x0 = 8 + 64 * c;
                int y0 = 60 + 16 * r;
                if (m_alive[r][c] && x >= x0 && x < x0 + 56 && y >= y0 && y < y0 + 12)
                    return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic bit model_find(input int bx, input int by, output int hr, output int hc);
        hr = 0;
        hc = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                int x0 = 8 + 64 * c;
                int y0 = 60 + 16 * r;
                if (m_alive[r][c] && bx < x0 + 56 && x0 < bx + 8 && by < y0 + 12 && y0 < by + 8) begin
                    hr = r;
                    hc = c;
                    return 1'b1;
                end
            end
        return 1'b0;
    endfunction

    task automatic pixel_check(input string name, input int x, input int y, input int exp);
        pix_x = 10'(x);
        pix_y = 10'(y);
        tick();
        check(name, int'(brick_on), exp);
    endtask

    // One ball strobe; with hold set, ball_valid stays high (with fresh random
    // positions) for the whole scan and must be ignored.
    task automatic run_scan(input string name, input int x, input int y, input bit hold);
        int hr, hc, exp_k, hits, got_k, got_r, got_c;
        bit found, done;
        found = model_find(x, y, hr, hc);
        exp_k = found ? (hr * COLS + hc + 2) : (NB + 1);
        ball_x = 10'(x);
        ball_y = 10'(y);
        ball_valid = 1'b1;
        tick();
        if (!hold) ball_valid = 1'b0;
        check({name, "_busy_rise"}, int'(busy), 1);
        hits = 0; got_k = 0; got_r = 0; got_c = 0; done = 1'b0;
        for (int k = 1; k <= NB + 5; k++) begin
            if (hold) begin
                ball_x = 10'($urandom_range(0, 560));
                ball_y = 10'($urandom_range(50, 120));
            end
            tick();
            if (hit) begin
                hits++;
                got_r = int'(hit_row);
                got_c = int'(hit_col);
            end
            if (!busy) begin
                got_k = k;
                done = 1'b1;
                ball_valid = 1'b0;
                break;
            end
        end
        ball_valid = 1'b0;
        check({name, "_done"}, int'(done), 1);
        check({name, "_latency"}, got_k, exp_k);
        check({name, "_hits"}, hits, found ? 1 : 0);
        if (found) begin
            m_alive[hr][hc] = 1'b0;
            m_left--;
            if (m_left == 0) m_cleared = 1'b1;
            check({name, "_row"}, got_r, hr);
            check({name, "_col"}, got_c, hc);
        end
        check({name, "_left"}, int'(bricks_left), m_left);
        check({name, "_cleared"}, int'(cleared), int'(m_cleared));
    endtask

    typedef struct {
        int px;
        int py;
        int exp;
    } pix_vec_t;

    pix_vec_t pv[$];

    initial begin
        int hits;

        pv.push_back('{8, 60, 1});
        pv.push_back('{64, 60, 0});
        pv.push_back('{72, 60, 1});
        pv.push_back('{7, 60, 0});
        pv.push_back('{8, 59, 0});
        pv.push_back('{63, 60, 1});
        pv.push_back('{8, 71, 1});
        pv.push_back('{8, 72, 0});
        pv.push_back('{8, 76, 1});
        pv.push_back('{519, 60, 0});
        pv.push_back('{456, 60, 1});
        pv.push_back('{520, 60, 0});
        pv.push_back('{8, 92, 1});
        pv.push_back('{8, 108, 0});
        pv.push_back('{0, 0, 0});

        model_fill();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_brick_on", int'(brick_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_left", int'(bricks_left), NB);
        check("rst_cleared", int'(cleared), 0);
        check("rst_hit_row", int'(hit_row), 0);
        check("rst_hit_col", int'(hit_col), 0);

        for (int i = 0; i < pv.size(); i++)
            pixel_check($sformatf("pix_vec%0d", i), pv[i].px, pv[i].py, pv[i].exp);

        run_scan("ball_10_62", 10, 62, 1'b0);
        pixel_check("pix_dead_00", 8, 60, 0);
        run_scan("ball_60_62", 60, 62, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_scan($sformatf("rnd%0d", i), $urandom_range(0, 560), $urandom_range(50, 120), 1'b0);
            for (int j = 0; j < 3; j++) begin
                int x = $urandom_range(0, 580);
                int y = $urandom_range(50, 115);
                pixel_check($sformatf("rnd_pix%0d_%0d", i, j), x, y, int'(model_pixel(x, y)));
            end
        end

        // load three clocks into a scan aimed at a live brick
        load = 1'b1;
        tick();
        load = 1'b0;
        model_fill();
        check("load_left", int'(bricks_left), NB);
        run_scan("pre_load_kill", 8 + 64 * 3 + 24, 62, 1'b0);
        ball_x = 10'(8 + 64 * 5 + 24);
        ball_y = 10'(60 + 32 + 2);
        ball_valid = 1'b1;
        tick();
        ball_valid = 1'b0;
        tick();
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        model_fill();
        check("midload_busy", int'(busy), 0);
        check("midload_hit", int'(hit), 0);
        check("midload_left", int'(bricks_left), NB);
        check("midload_cleared", int'(cleared), 0);
        hits = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (hit) hits++;
        end
        check("midload_no_hit", hits, 0);
        pixel_check("midload_pix", 8 + 64 * 3, 60, 1);

        run_scan("held_valid", 8 + 64 * 2 + 24, 78, 1'b1);

        load = 1'b1;
        tick();
        load = 1'b0;
        model_fill();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                run_scan($sformatf("kill_r%0d_c%0d", r, c), 8 + 64 * c + 24, 60 + 16 * r + 2, 1'b0);
        check("all_cleared", int'(cleared), 1);
        run_scan("empty_wall", 32, 62, 1'b0);
        check("empty_left", int'(bricks_left), 0);

        // rst in the middle of a scan on the empty wall
        ball_x = 10'd32;
        ball_y = 10'd62;
        ball_valid = 1'b1;
        tick();
        ball_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_fill();
        check("mrst_brick_on", int'(brick_on), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_hit", int'(hit), 0);
        check("mrst_hit_row", int'(hit_row), 0);
        check("mrst_hit_col", int'(hit_col), 0);
        check("mrst_left", int'(bricks_left), NB);
        check("mrst_cleared", int'(cleared), 0);
        pixel_check("mrst_pix", 8, 60, 1);
        run_scan("post_rst", 10, 62, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brick_wall.md
Name: brick_wall

Overview:
- Parametrised brick field for the breakout game. Replaces the fixed six-brick row with a ROWS x COLS grid.
- Holds a per-brick alive bit and answers two questions:
  - per pixel: is this pixel on a live brick? (feeds pixel generation)
  - per ball update: does the ball overlap a live brick? (sequential scan; the brick is destroyed and a hit pulse is sent to the score counter)
- Sits between the ball/paddle logic and pixel_generation/score in the top level.

Parameters:
- COLS, 8, bricks per row (1..16)
- ROWS, 3, brick rows (1..8)
- ORIGIN_X, 8, x of column 0 left edge (pixels)
- ORIGIN_Y, 60, y of row 0 top edge (pixels)
- COL_SHIFT, 6, column pitch = 2**COL_SHIFT pixels
- ROW_SHIFT, 4, row pitch = 2**ROW_SHIFT pixels
- BRICK_W, 56, brick width (must be < column pitch)
- BRICK_H, 12, brick height (must be < row pitch)
- BALL_SIZE, 8, ball square side (pixels)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous active-high reset
- load  in  1  one-cycle strobe: repopulate the full wall
- ball_valid  in  1  one-cycle strobe: new ball position on ball_x/ball_y
- ball_x  in  10  ball top-left x
- ball_y  in  10  ball top-left y
- pix_x  in  10  current VGA pixel x
- pix_y  in  10  current VGA pixel y
- brick_on  out  1  registered: pixel (pix_x, pix_y) lies on a live brick
- busy  out  1  collision scan in progress
- hit  out  1  one-cycle pulse: a brick was destroyed
- hit_row  out  3  row of destroyed brick, valid with hit
- hit_col  out  4  column of destroyed brick, valid with hit
- bricks_left  out  8  live brick count
- cleared  out  1  sticky: wall empty

Behaviour:
- Reset values:
  - alive = all ones (ROWS*COLS bits)
  - bricks_left = ROWS*COLS
  - brick_on, busy, hit, cleared = 0
  - hit_row, hit_col = 0
  - FSM in IDLE
- Pixel path (independent of the FSM):
  - dx = pix_x - ORIGIN_X; dy = pix_y - ORIGIN_Y (11-bit signed).
  - col = dx >> COL_SHIFT; row = dy >> ROW_SHIFT.
  - brick_on is set on the next clk when all of these hold:
    - dx >= 0 and dy >= 0
    - col < COLS and row < ROWS
    - dx[COL_SHIFT-1:0] < BRICK_W and dy[ROW_SHIFT-1:0] < BRICK_H
    - alive[row*COLS+col]
  - Latency is 1 clk. The top level compensates with its existing p_tick register stage.
- FSM states: IDLE, SCAN, REPORT.
  - IDLE:
    - On ball_valid: latch ball_x/ball_y, set idx=0, busy=1, go to SCAN.
  - SCAN (one brick per clk, idx = row*COLS+col, row-major):
    - Brick box is bx = ORIGIN_X + col<<COL_SHIFT, by = ORIGIN_Y + row<<ROW_SHIFT.
    - Overlap test: ball_x < bx+BRICK_W && bx < ball_x+BALL_SIZE && ball_y < by+BRICK_H && by < ball_y+BALL_SIZE.
    - Compute the test in 11 bits so there is no wrap.
    - First alive overlapping brick: clear its alive bit, latch row/col, go to REPORT.
    - Otherwise, if idx == ROWS*COLS-1, go to REPORT with no hit.
    - Otherwise, idx++.
  - REPORT (1 clk):
    - On a hit: hit=1, hit_row/hit_col driven, bricks_left decremented.
    - If bricks_left reaches 0, cleared=1.
    - Then busy=0 and go to IDLE.
- Hit rules:
  - At most one brick is destroyed per ball_valid; the lowest index wins.
  - Worst-case latency from ball_valid to hit/busy fall is ROWS*COLS+1 clks.
- ball_valid while busy is ignored; no queueing.
- load:
  - Any state: alive = all ones, bricks_left = ROWS*COLS, cleared=0, FSM to IDLE, busy=0, hit=0.
  - load takes priority over ball_valid and an in-flight scan in the same cycle.
  - rst takes priority over load.
- bricks_left never underflows. A scan with bricks_left == 0 completes with no hit.

Decomposition:
- Package brick_pkg holds:
  - localparams NBRICKS = ROWS*COLS
  - index widths via $clog2
  - the FSM state enum
  - 10-bit coordinate typedef shared with the board, ball and pixel_generation blocks
- One sub-module, brick_overlap: purely combinational AABB test (ball box vs brick box, 11-bit compare).
  - Instantiated once in the scan path.
  - Reused by the paddle/ball block later.

Test Plan:
- Reset, then pix=(8,60) → brick_on=1 one clk later; pix=(64,60) (gap, dx[5:0]=56) → 0; pix=(72,60) → 1; bricks_left=24, cleared=0.
- ball_valid with ball=(10,62) → busy=1; hit pulses exactly once with row=0, col=0 on the 2nd clk after the strobe; bricks_left=23; pix=(8,60) → brick_on=0 afterwards.
- ball=(60,62), overlapping the gap edge of col 0 (already dead) and col 1 at x=72? No: x 60..67 vs col1 72.. → no overlap. Scan runs 24 clks, then busy falls with no hit; bricks_left unchanged.
- Destroy all 24 bricks via 24 targeted strobes → cleared rises with the 24th hit; a 25th strobe completes with no hit and bricks_left stays 0.
- load asserted mid-scan (3 clks after ball_valid on a live brick) → no hit pulse, busy=0 next clk, bricks_left=24, cleared=0.
- ball_valid repeated every clk while busy → only the first is serviced, with a single hit; rst mid-scan → all outputs return to reset values next clk.
